// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command-frame parser:
//   - state_e            parser state encoding
//   - OPC_WR / OPC_RD    legal opcode bytes
//   - ERR_*              error reason codes reported on err_code
//   - DEFAULT_SYNC_BYTE  default frame start marker
//   - frame_csum()       checksum rule for a frame (OPC ^ ADDR ^ DATA)
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_OPC  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_CSUM = 3'd4,
      ST_HOLD = 3'd5
   } state_e;

   localparam logic [7:0] OPC_WR = 8'h01;
   localparam logic [7:0] OPC_RD = 8'h02;

   localparam logic [1:0] ERR_OVERRUN = 2'd0;
   localparam logic [1:0] ERR_OPCODE  = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   function automatic logic [7:0] frame_csum(input logic [7:0] opc,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
      return opc ^ addr ^ data;
   endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// -----------------------------------------------------------------------------
// uart_cmd_timer
// Inter-byte idle timer for the command parser. Counts clk cycles while
// enabled; any clear or a dropped enable returns the count to zero. The
// expiry flag is high in the cycle the count sits at TIMEOUT_CYCLES-1.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   enable   in   count while high (parser is inside a frame)
//   clear    in   restart the count (byte received or state change)
//   expired  out  count has reached TIMEOUT_CYCLES-1 while enabled
// -----------------------------------------------------------------------------
module uart_cmd_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   // TIMEOUT_CYCLES-1 always fits in clog2(TIMEOUT_CYCLES) bits.
   localparam int unsigned    CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: reset is synchronous, so it lives inside the clocked branch and the
   // sensitivity list carries only the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || !enable) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         // Hold at the terminal value instead of wrapping; the parser leaves
         // the frame on expiry, so this only guards against aliasing.
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = enable && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Assembles 5-byte command frames (SYNC, OPC, ADDR, DATA, CSUM) from the UART
// receiver byte stream, validates opcode and checksum, and offers the decoded
// register access to the SJA1000 bus-interface block over valid/ready.
// Bad opcodes, checksum failures, inter-byte timeouts and bytes arriving while
// a command waits are reported on err_pulse/err_code and counted in err_cnt.
//
// Parameters:
//   TIMEOUT_CYCLES  max idle clk cycles between bytes inside a frame (2..2^20)
//   SYNC_BYTE       frame start marker
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   rx_data[7:0]   in   received byte, qualified by rx_data_valid
//   rx_data_valid  in   one-cycle strobe for a new byte
//   cmd_valid      out  command pending (registered)
//   cmd_ready      in   consumer accepts the command
//   cmd_wr         out  1 = write, 0 = read
//   cmd_addr[7:0]  out  register address
//   cmd_wdata[7:0] out  write data (carried unchanged on reads)
//   err_pulse      out  one-cycle error strobe
//   err_code[1:0]  out  error reason, valid with err_pulse
//   err_cnt[7:0]   out  saturating error count
// -----------------------------------------------------------------------------
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_data_valid,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic       cmd_wr,
   output logic [7:0] cmd_addr,
   output logic [7:0] cmd_wdata,
   output logic       err_pulse,
   output logic [1:0] err_code,
   output logic [7:0] err_cnt
);

   state_e     state;
   state_e     state_nxt;

   logic       err_set;
   logic [1:0] err_code_nxt;
   logic       ld_wr;
   logic       ld_addr;
   logic       ld_data;

   logic       in_frame;
   logic       tmr_clear;
   logic       tmr_expired;
   logic [7:0] csum_exp;
   logic       is_sync;
   logic       is_opcode;

   assign is_sync   = (rx_data == SYNC_BYTE);
   assign is_opcode = (rx_data == OPC_WR) || (rx_data == OPC_RD);

   // Only two opcodes are legal, so the latched direction bit recovers the
   // opcode byte and no separate OPC register is needed for the checksum.
   assign csum_exp = frame_csum(cmd_wr ? OPC_WR : OPC_RD, cmd_addr, cmd_wdata);

   // The timer runs only while collecting frame bytes; HOLD is not timed.
   assign in_frame  = (state == ST_OPC) || (state == ST_ADDR) ||
                      (state == ST_DATA) || (state == ST_CSUM);
   assign tmr_clear = rx_data_valid || (state_nxt != state);

   uart_cmd_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .enable  (in_frame),
      .clear   (tmr_clear),
      .expired (tmr_expired)
   );

   // ---------------------------------------------------------------------------
   // Next-state and load decode
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned in this block gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt    = state;
      err_set      = 1'b0;
      err_code_nxt = ERR_OVERRUN;
      ld_wr        = 1'b0;
      ld_addr      = 1'b0;
      ld_data      = 1'b0;

      case (state)
         ST_IDLE: begin
            // Anything but the marker is line noise and is dropped silently.
            if (rx_data_valid && is_sync) state_nxt = ST_OPC;
         end

         ST_OPC: begin
            if (rx_data_valid) begin
               if (is_opcode) begin
                  ld_wr     = 1'b1;
                  state_nxt = ST_ADDR;
               end else begin
                  // A repeated sync byte lands here too: no resynchronisation.
                  err_set      = 1'b1;
                  err_code_nxt = ERR_OPCODE;
                  state_nxt    = ST_IDLE;
               end
            end
         end

         ST_ADDR: begin
            if (rx_data_valid) begin
               ld_addr   = 1'b1;
               state_nxt = ST_DATA;
            end
         end

         ST_DATA: begin
            if (rx_data_valid) begin
               ld_data   = 1'b1;
               state_nxt = ST_CSUM;
            end
         end

         ST_CSUM: begin
            if (rx_data_valid) begin
               if (rx_data == csum_exp) begin
                  state_nxt = ST_HOLD;
               end else begin
                  err_set      = 1'b1;
                  err_code_nxt = ERR_CSUM;
                  state_nxt    = ST_IDLE;
               end
            end
         end

         ST_HOLD: begin
            if (cmd_ready) begin
               // Handshake completes; a byte in this same cycle is judged as
               // an IDLE byte so a sync starts the next frame immediately.
               state_nxt = (rx_data_valid && is_sync) ? ST_OPC : ST_IDLE;
            end else if (rx_data_valid) begin
               err_set      = 1'b1;
               err_code_nxt = ERR_OVERRUN;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // Expiry only matters in a cycle with no byte: a byte in the expiry
      // cycle takes precedence and is processed by the case above.
      if (in_frame && tmr_expired && !rx_data_valid) begin
         err_set      = 1'b1;
         err_code_nxt = ERR_TIMEOUT;
         state_nxt    = ST_IDLE;
      end
   end

   // ---------------------------------------------------------------------------
   // State, field and error registers
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register here
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cmd_valid <= 1'b0;
         cmd_wr    <= 1'b0;
         cmd_addr  <= 8'h00;
         cmd_wdata <= 8'h00;
         err_pulse <= 1'b0;
         err_code  <= ERR_OVERRUN;
         err_cnt   <= 8'h00;
      end else begin
         state     <= state_nxt;
         // Registered copy of "next state is HOLD" keeps cmd_valid glitch-free.
         cmd_valid <= (state_nxt == ST_HOLD);

         // Fields load only in the frame-collection states, never in HOLD, so
         // they stay stable for as long as cmd_valid is high.
         if (ld_wr)   cmd_wr    <= (rx_data == OPC_WR);
         if (ld_addr) cmd_addr  <= rx_data;
         if (ld_data) cmd_wdata <= rx_data;

         err_pulse <= err_set;
         if (err_set) begin
            err_code <= err_code_nxt;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule
